// File: rtl/mpg_pkg.sv
// Shared constants for the multi-channel period generator: register map and bus width.
package mpg_pkg;

  localparam int unsigned MPG_DATA_W      = 32;

  localparam int unsigned MPG_CTRL        = 0;
  localparam int unsigned MPG_MODE        = 1;
  localparam int unsigned MPG_STATUS      = 2;
  localparam int unsigned MPG_IRQMASK     = 3;
  localparam int unsigned MPG_PERIOD_BASE = 4;

  // Decoded selects for the fixed (non-period) registers
  typedef struct packed {
    logic ctrl;
    logic mode;
    logic status;
    logic irq_mask;
  } mpg_reg_sel_t;

endpackage

// File: rtl/mpg_chan.sv
// One period-generator channel: down-counter with reload, registered tick and square wave.
module mpg_chan #(
  parameter int unsigned PERIOD_W = 28
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                en_rise,
  input  logic [PERIOD_W-1:0] period,
  output logic                expire_c,
  output logic                tick,
  output logic                wave
);

  logic [PERIOD_W-1:0] cnt_q;
  logic                live_c;

  // A zero period parks the channel with counter and wave frozen
  assign live_c   = en && (period != '0);
  assign expire_c = live_c && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tick  <= 1'b0;
      wave  <= 1'b0;
    end else begin
      tick <= expire_c;
      if (expire_c) begin
        wave <= ~wave;
      end
      // Reload samples the period only here, so mid-count writes apply next interval
      if (en_rise || expire_c) begin
        cnt_q <= period - PERIOD_W'(1);
      end else if (live_c) begin
        cnt_q <= cnt_q - PERIOD_W'(1);
      end
    end
  end

endmodule

// File: rtl/multi_period_gen.sv
// N_CH-channel programmable period generator on an Avalon-MM slave.
// Define MPG_IRQ_EN to build the IRQ_MASK register and the irq output.
module multi_period_gen
  import mpg_pkg::*;
#(
  parameter int unsigned N_CH     = 8,
  parameter int unsigned PERIOD_W = 28,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [ADDR_W-1:0]     avs_address,
  input  logic                  avs_write,
  input  logic                  avs_read,
  input  logic [MPG_DATA_W-1:0] avs_writedata,
  output logic [MPG_DATA_W-1:0] avs_readdata,
  output logic [N_CH-1:0]       tick_out,
  output logic [N_CH-1:0]       wave_out,
  output logic                  irq
);

  logic [MPG_DATA_W-1:0] addr_c;
  mpg_reg_sel_t          sel_c;
  logic [N_CH-1:0]       per_sel_c;
  logic [N_CH-1:0]       wmask_c;

  logic [N_CH-1:0]       ctrl_q;
  logic [N_CH-1:0]       ctrl_d;
  logic [N_CH-1:0]       mode_q;
  logic [N_CH-1:0]       status_q;
  logic [N_CH-1:0]       status_d;
  logic [N_CH-1:0]       en_rise_c;
  logic [N_CH-1:0]       expire_c;
  logic [PERIOD_W-1:0]   period_q [N_CH];
  logic [MPG_DATA_W-1:0] rdata_c;
  logic                  unused_c;
`ifdef MPG_IRQ_EN
  logic [N_CH-1:0]       irq_mask_q;
`endif

  assign wmask_c  = avs_writedata[N_CH-1:0];
  assign unused_c = ^{avs_writedata, sel_c};

  // Address decode
  always_comb begin
    addr_c         = MPG_DATA_W'(avs_address);
    sel_c.ctrl     = (addr_c == MPG_CTRL);
    sel_c.mode     = (addr_c == MPG_MODE);
    sel_c.status   = (addr_c == MPG_STATUS);
    sel_c.irq_mask = (addr_c == MPG_IRQMASK);
    for (int unsigned k = 0; k < N_CH; k++) begin
      per_sel_c[k] = (addr_c == MPG_PERIOD_BASE + k);
    end
  end

  // Software CTRL write overrides one-shot clear; hardware expiry overrides W1C
  always_comb begin
    ctrl_d = ctrl_q & ~(expire_c & mode_q);
    if (avs_write && sel_c.ctrl) begin
      ctrl_d = wmask_c;
    end
    status_d = status_q;
    if (avs_write && sel_c.status) begin
      status_d = status_q & ~wmask_c;
    end
    status_d  = status_d | expire_c;
    en_rise_c = ctrl_d & ~ctrl_q;
  end

  // Read mux uses current register values, so a same-cycle write is not visible
  always_comb begin
    rdata_c = '0;
    if (sel_c.ctrl) begin
      rdata_c = MPG_DATA_W'(ctrl_q);
    end
    if (sel_c.mode) begin
      rdata_c = MPG_DATA_W'(mode_q);
    end
    if (sel_c.status) begin
      rdata_c = MPG_DATA_W'(status_q);
    end
`ifdef MPG_IRQ_EN
    if (sel_c.irq_mask) begin
      rdata_c = MPG_DATA_W'(irq_mask_q);
    end
`endif
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (per_sel_c[k]) begin
        rdata_c = MPG_DATA_W'(period_q[k]);
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ctrl_q       <= '0;
      mode_q       <= '0;
      status_q     <= '0;
      avs_readdata <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      status_q <= status_d;
      if (avs_write && sel_c.mode) begin
        mode_q <= wmask_c;
      end
      if (avs_read) begin
        avs_readdata <= rdata_c;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        period_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (avs_write && per_sel_c[k]) begin
          period_q[k] <= avs_writedata[PERIOD_W-1:0];
        end
      end
    end
  end

`ifdef MPG_IRQ_EN
  // irq follows the registered STATUS, one cycle behind it
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      irq_mask_q <= '0;
      irq        <= 1'b0;
    end else begin
      if (avs_write && sel_c.irq_mask) begin
        irq_mask_q <= wmask_c;
      end
      irq <= |(status_q & irq_mask_q);
    end
  end
`else
  assign irq = 1'b0;
`endif

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    mpg_chan #(
      .PERIOD_W (PERIOD_W)
    ) u_chan (
      .clk      (clk_clk),
      .rst_n    (reset_reset_n),
      .en       (ctrl_q[k]),
      .en_rise  (en_rise_c[k]),
      .period   (period_q[k]),
      .expire_c (expire_c[k]),
      .tick     (tick_out[k]),
      .wave     (wave_out[k])
    );
  end

endmodule

// File: tb/tb_multi_period_gen.sv
// Self-checking bench for multi_period_gen: directed scenarios plus random bus traffic
// against a timestamp-based reference model.
module tb_multi_period_gen;
  import mpg_pkg::*;

  localparam int unsigned N_CH     = 8;
  localparam int unsigned PERIOD_W = 28;
  localparam int unsigned ADDR_W   = 5;

  logic                clk_clk       = 1'b0;
  logic                reset_reset_n = 1'b0;
  logic [ADDR_W-1:0]   avs_address   = '0;
  logic                avs_write     = 1'b0;
  logic                avs_read      = 1'b0;
  logic [31:0]         avs_writedata = '0;
  logic [31:0]         avs_readdata;
  logic [N_CH-1:0]     tick_out;
  logic [N_CH-1:0]     wave_out;
  logic                irq;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: each channel keeps the absolute edge number of its next expiry
  int unsigned         t;
  int unsigned         m_next [N_CH];
  logic [PERIOD_W-1:0] m_per  [N_CH];
  logic [N_CH-1:0]     m_en, m_mode, m_status, m_mask, m_tick, m_wave;
  logic                m_irq;
  logic [31:0]         m_rd;

  multi_period_gen #(
    .N_CH     (N_CH),
    .PERIOD_W (PERIOD_W),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_read      (avs_read),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .tick_out      (tick_out),
    .wave_out      (wave_out),
    .irq           (irq)
  );

  always #5 clk_clk = ~clk_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    for (int k = 0; k < N_CH; k++) begin
      m_next[k] = 0;
      m_per[k]  = '0;
    end
    m_en = '0; m_mode = '0; m_status = '0; m_mask = '0;
    m_tick = '0; m_wave = '0; m_irq = 1'b0; m_rd = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [ADDR_W-1:0] a);
    int unsigned ai;
    ai = 32'(a);
    model_read = '0;
    if (ai == MPG_CTRL) model_read = 32'(m_en);
    else if (ai == MPG_MODE) model_read = 32'(m_mode);
    else if (ai == MPG_STATUS) model_read = 32'(m_status);
`ifdef MPG_IRQ_EN
    else if (ai == MPG_IRQMASK) model_read = 32'(m_mask);
`endif
    else if (ai >= MPG_PERIOD_BASE && ai < MPG_PERIOD_BASE + N_CH)
      model_read = 32'(m_per[ai - MPG_PERIOD_BASE]);
  endfunction

  // Apply the rules for one clock edge using pre-edge register values
  task automatic model_edge(input logic wr, input logic rd,
                            input logic [ADDR_W-1:0] a, input logic [31:0] d);
    logic [N_CH-1:0] exp_v, new_en, wm;
    logic            irq_n;
    int unsigned     ai;
    ai = 32'(a);
    wm = d[N_CH-1:0];
    exp_v = '0;
    for (int k = 0; k < N_CH; k++)
      if (m_en[k] && m_per[k] != '0 && m_next[k] == t) exp_v[k] = 1'b1;
`ifdef MPG_IRQ_EN
    irq_n = |(m_status & m_mask);
`else
    irq_n = 1'b0;
`endif
    if (rd) m_rd = model_read(a);
    new_en = m_en & ~(exp_v & m_mode);
    if (wr && ai == MPG_CTRL) new_en = wm;
    for (int k = 0; k < N_CH; k++)
      if ((new_en[k] && !m_en[k]) || exp_v[k]) m_next[k] = t + 32'(m_per[k]);
    if (wr && ai == MPG_STATUS) m_status = m_status & ~wm;
    m_status = m_status | exp_v;
    if (wr && ai == MPG_MODE) m_mode = wm;
`ifdef MPG_IRQ_EN
    if (wr && ai == MPG_IRQMASK) m_mask = wm;
`endif
    if (wr && ai >= MPG_PERIOD_BASE && ai < MPG_PERIOD_BASE + N_CH)
      m_per[ai - MPG_PERIOD_BASE] = d[PERIOD_W-1:0];
    m_en   = new_en;
    m_tick = exp_v;
    m_wave = m_wave ^ exp_v;
    m_irq  = irq_n;
    t++;
  endtask

  task automatic step(input logic wr, input logic rd,
                      input logic [ADDR_W-1:0] a, input logic [31:0] d);
    avs_write = wr; avs_read = rd; avs_address = a; avs_writedata = d;
    @(posedge clk_clk);
    model_edge(wr, rd, a, d);
    #1;
    avs_write = 1'b0; avs_read = 1'b0;
    chk("tick", 32'(tick_out), 32'(m_tick));
    chk("wave", 32'(wave_out), 32'(m_wave));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("rdata", avs_readdata, m_rd);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0);
  endtask

  task automatic wr(input int unsigned a, input logic [31:0] d);
    step(1'b1, 1'b0, ADDR_W'(a), d);
  endtask

  task automatic rd(input int unsigned a);
    step(1'b0, 1'b1, ADDR_W'(a), '0);
  endtask

  initial begin
    logic [ADDR_W-1:0] ra;
    logic [31:0]       rdv;
    int unsigned       r;

    model_reset();
    repeat (3) @(posedge clk_clk);
    #1;
    chk("rst_tick", 32'(tick_out), 32'd0);
    chk("rst_wave", 32'(wave_out), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rdata", avs_readdata, 32'd0);
    reset_reset_n = 1'b1;

    // Continuous channel 0, period 4: ticks at 4, 8, 12 after the CTRL write
    wr(MPG_PERIOD_BASE + 0, 32'd4);
    wr(MPG_CTRL, 32'h1);
    for (int i = 1; i <= 12; i++) begin
      idle();
      chk("p4_tick", 32'(tick_out[0]), 32'(i % 4 == 0));
      chk("p4_wave", 32'(wave_out[0]), 32'((i / 4) % 2));
    end
    wr(MPG_CTRL, 32'h0);

    // One-shot channel 1, period 3
    wr(MPG_STATUS, 32'hFFFF_FFFF);
    wr(MPG_MODE, 32'h2);
    wr(MPG_PERIOD_BASE + 1, 32'd3);
    wr(MPG_CTRL, 32'h2);
    for (int i = 1; i <= 6; i++) begin
      idle();
      chk("os_tick", 32'(tick_out[1]), 32'(i == 3));
    end
    rd(MPG_CTRL);
    chk("os_ctrl", avs_readdata, 32'd0);
    rd(MPG_STATUS);
    chk("os_status", avs_readdata, 32'd2);
    wr(MPG_MODE, 32'h0);

    // Period rewrite mid-count on channel 2: interval 10 completes, then 2
    wr(MPG_PERIOD_BASE + 2, 32'd10);
    wr(MPG_CTRL, 32'h4);
    for (int i = 1; i <= 14; i++) begin
      if (i == 4) wr(MPG_PERIOD_BASE + 2, 32'd2);
      else idle();
      chk("rewr_tick", 32'(tick_out[2]), 32'(i == 10 || i == 12 || i == 14));
    end
    wr(MPG_CTRL, 32'h0);

    // W1C of STATUS[0] on the same edge as channel 0 expiry
    wr(MPG_STATUS, 32'hFFFF_FFFF);
    wr(MPG_CTRL, 32'h1);
    repeat (3) idle();
    wr(MPG_STATUS, 32'h1);
    chk("w1c_tick", 32'(tick_out[0]), 32'd1);
    rd(MPG_STATUS);
    chk("w1c_status", avs_readdata, 32'd1);
    wr(MPG_CTRL, 32'h0);

`ifdef MPG_IRQ_EN
    wr(MPG_STATUS, 32'hFFFF_FFFF);
    wr(MPG_IRQMASK, 32'h1);
    rd(MPG_IRQMASK);
    chk("irq_mask", avs_readdata, 32'd1);
    wr(MPG_CTRL, 32'h1);
    repeat (4) idle();
    chk("irq_pre", 32'(irq), 32'd0);
    idle();
    chk("irq_set", 32'(irq), 32'd1);
    wr(MPG_CTRL, 32'h0);
    wr(MPG_STATUS, 32'h1);
    chk("irq_hold", 32'(irq), 32'd1);
    idle();
    chk("irq_clr", 32'(irq), 32'd0);
    wr(MPG_IRQMASK, 32'h0);
`else
    wr(MPG_IRQMASK, 32'h1);
    rd(MPG_IRQMASK);
    chk("irqmask_absent", avs_readdata, 32'd0);
    chk("irq_tied", 32'(irq), 32'd0);
`endif

    // Mask width, unmapped addresses, read+write same cycle
    wr(MPG_MODE, 32'hFFFF_FFFF);
    rd(MPG_MODE);
    chk("mode_width", avs_readdata, 32'h0000_00FF);
    wr(MPG_MODE, 32'h0);
    wr(20, 32'hDEAD_BEEF);
    rd(20);
    chk("unmapped20", avs_readdata, 32'd0);
    rd(31);
    chk("unmapped31", avs_readdata, 32'd0);
    step(1'b1, 1'b1, ADDR_W'(MPG_PERIOD_BASE + 3), 32'hF000_0005);
    chk("rw_pre", avs_readdata, 32'd0);
    rd(MPG_PERIOD_BASE + 3);
    chk("rw_post", avs_readdata, 32'd5);

    // Asynchronous reset while channel 0 is counting
    wr(MPG_CTRL, 32'h1);
    repeat (6) idle();
    #2;
    reset_reset_n = 1'b0;
    #1;
    chk("arst_tick", 32'(tick_out), 32'd0);
    chk("arst_wave", 32'(wave_out), 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    chk("arst_rdata", avs_readdata, 32'd0);
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
    model_reset();
    rd(MPG_CTRL);
    chk("arst_ctrl", avs_readdata, 32'd0);

    // Random traffic; periods kept nonzero so every enabled channel is live
    for (int k = 0; k < N_CH; k++) wr(MPG_PERIOD_BASE + k, 32'($urandom_range(1, 7)));
    for (int i = 0; i < 600; i++) begin
      r   = $urandom_range(0, 99);
      ra  = ADDR_W'($urandom_range(0, MPG_PERIOD_BASE + N_CH + 1));
      rdv = $urandom;
      if (32'(ra) >= MPG_PERIOD_BASE)
        rdv = (rdv & 32'hF000_0000) | 32'($urandom_range(1, 7));
      if (r < 55) idle();
      else if (r < 85) step(1'b1, 1'b0, ra, rdv);
      else if (r < 95) step(1'b0, 1'b1, ra, '0);
      else step(1'b1, 1'b1, ra, rdv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
